// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register result-latency counters for RAW interlocks
// and a DIV_CYCLES-long divider occupancy FSM that guards HI/LO readers and back-to-back divides.
module hazard_scoreboard #(
    parameter int NREG       = 32,
    parameter int RAW        = 5,
    parameter int MAX_LAT    = 7,
    parameter int FWD_LAT    = 1,
    parameter int DIV_CYCLES = 34,
    localparam int CW        = $clog2(MAX_LAT + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issueD,
    input  logic [RAW-1:0] rsD,
    input  logic [RAW-1:0] rtD,
    input  logic           use_rsD,
    input  logic           use_rtD,
    input  logic [RAW-1:0] dstD,
    input  logic           regwriteD,
    input  logic [CW-1:0]  latD,
    input  logic           divD,
    input  logic           hiloreadD,
    input  logic           flush_all,
    output logic           stallF,
    output logic           stallD,
    output logic           flushE,
    output logic           div_busy,
    output logic           hilo_valid,
    output logic [31:0]    stall_count
);

    localparam int DCW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    div_state_e     state_q;
    logic [DCW-1:0] divcnt_q;
    logic [CW-1:0]  cnt_q [NREG];
    logic [CW-1:0]  cnt_d [NREG];
    logic [31:0]    stall_cnt_q;
    logic [31:0]    stall_cnt_d;
    logic           raw_stall;
    logic           div_stall;
    logic           stall;
    logic           accept;
    logic           load;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        raw_stall = issueD & ((use_rsD & (cnt_q[rsD] > CW'(FWD_LAT))) |
                              (use_rtD & (cnt_q[rtD] > CW'(FWD_LAT))));
        div_stall = issueD & div_busy & (divD | hiloreadD);
        // A flush discards the instruction in decode, so it must never be held.
        stall     = (raw_stall | div_stall) & ~flush_all;
        accept    = issueD & ~stall & ~flush_all;
        load      = accept & regwriteD & (dstD != '0);
    end

    assign stallF      = stall;
    assign stallD      = stall;
    assign flushE      = stall;
    assign div_busy    = (state_q == BUSY);
    assign hilo_valid  = (state_q == DONE) & ~flush_all;
    assign stall_count = stall_cnt_q;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0 || flush_all) begin
                cnt_d[r] = '0;
            end else if (load && dstD == RAW'(r)) begin
                cnt_d[r] = latD;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Divider occupancy: BUSY lasts DIV_CYCLES cycles, DONE is the single commit cycle.
    always_ff @(posedge clk) begin
        if (rst || flush_all) begin
            state_q  <= IDLE;
            divcnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && divD) begin
                        state_q  <= BUSY;
                        divcnt_q <= DCW'(DIV_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (divcnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        divcnt_q <= divcnt_q - DCW'(1);
                    end
                end
                DONE: begin
                    if (accept && divD) begin
                        state_q  <= BUSY;
                        divcnt_q <= DCW'(DIV_CYCLES - 1);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    divcnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a table of single-cycle decode vectors followed by
// hand-written divide, flush, same-register overwrite and stall-counter saturation sequences.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issueD;
    logic [4:0]  rsD, rtD, dstD;
    logic        use_rsD, use_rtD, regwriteD;
    logic [2:0]  latD;
    logic        divD, hiloreadD, flush_all;
    logic        stallF, stallD, flushE, div_busy, hilo_valid;
    logic [31:0] stall_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG(32), .RAW(5), .MAX_LAT(7), .FWD_LAT(1), .DIV_CYCLES(34)
    ) dut (
        .clk(clk), .rst(rst), .issueD(issueD), .rsD(rsD), .rtD(rtD),
        .use_rsD(use_rsD), .use_rtD(use_rtD), .dstD(dstD), .regwriteD(regwriteD),
        .latD(latD), .divD(divD), .hiloreadD(hiloreadD), .flush_all(flush_all),
        .stallF(stallF), .stallD(stallD), .flushE(flushE), .div_busy(div_busy),
        .hilo_valid(hilo_valid), .stall_count(stall_count)
    );

    typedef struct {
        int iss; int rs; int rt; int urs; int urt; int dst; int rw; int lat; int fl;
        int exp_stall; int exp_cnt;
    } vec_t;

    vec_t tbl[13];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle();
        issueD = 1'b0; rsD = 5'd0; rtD = 5'd0; use_rsD = 1'b0; use_rtD = 1'b0;
        dstD = 5'd0; regwriteD = 1'b0; latD = 3'd0; divD = 1'b0; hiloreadD = 1'b0;
        flush_all = 1'b0;
    endtask

    task automatic chk_stall(input string nm, input logic exp);
        chk1({nm, "_stallD"}, stallD, exp);
        chk1({nm, "_stallF"}, stallF, exp);
        chk1({nm, "_flushE"}, flushE, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int busy_seen;

        //           iss rs rt urs urt dst rw lat fl stall cnt
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 5, 1, 2, 0, 0, 0};
        tbl[2]  = '{1, 5, 0, 1, 0, 0, 0, 1, 0, 1, 0};
        tbl[3]  = '{1, 5, 0, 1, 0, 0, 0, 1, 0, 0, 1};
        tbl[4]  = '{1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1};
        tbl[5]  = '{1, 0, 7, 0, 1, 0, 0, 1, 0, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 1};
        tbl[7]  = '{1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1};
        tbl[8]  = '{1, 9, 0, 1, 0, 9, 1, 7, 0, 0, 1};
        tbl[9]  = '{1, 9, 1, 0, 1, 0, 0, 1, 0, 0, 1};
        tbl[10] = '{0, 9, 0, 1, 0, 0, 0, 1, 0, 0, 1};
        tbl[11] = '{1, 9, 0, 1, 0, 0, 0, 1, 1, 0, 1};
        tbl[12] = '{1, 9, 0, 1, 0, 0, 0, 1, 0, 0, 1};

        // Reset, with a divide and a write presented while rst is high.
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_stall("rst", 1'b0);
        chk1("rst_div_busy", div_busy, 1'b0);
        chk1("rst_hilo_valid", hilo_valid, 1'b0);
        chk32("rst_stall_count", stall_count, 32'd0);
        @(negedge clk);
        issueD = 1'b1; divD = 1'b1; regwriteD = 1'b1; dstD = 5'd6; latD = 3'd7;
        #1;
        chk_stall("rst_issue", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        issueD = 1'b1; use_rsD = 1'b1; rsD = 5'd6;
        #1;
        chk1("post_rst_div_busy", div_busy, 1'b0);
        chk1("post_rst_r6_stall", stallD, 1'b0);
        chk32("post_rst_stall_count", stall_count, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            idle();
            issueD    = tbl[i].iss[0];
            rsD       = tbl[i].rs[4:0];
            rtD       = tbl[i].rt[4:0];
            use_rsD   = tbl[i].urs[0];
            use_rtD   = tbl[i].urt[0];
            dstD      = tbl[i].dst[4:0];
            regwriteD = tbl[i].rw[0];
            latD      = tbl[i].lat[2:0];
            flush_all = tbl[i].fl[0];
            #1;
            chk_stall($sformatf("v%0d", i), tbl[i].exp_stall[0]);
            chk1($sformatf("v%0d_div_busy", i), div_busy, 1'b0);
            chk1($sformatf("v%0d_hilo", i), hilo_valid, 1'b0);
            chk32($sformatf("v%0d_stall_count", i), stall_count, 32'(tbl[i].exp_cnt));
            @(negedge clk);
        end

        // Divide accepted at t; HI/LO reader from t+2 stalls until the result commits.
        idle();
        issueD = 1'b1; divD = 1'b1;
        #1;
        chk_stall("div_t", 1'b0);
        chk1("div_t_busy", div_busy, 1'b0);
        @(negedge clk);
        for (int k = 1; k <= 34; k++) begin
            idle();
            if (k >= 2) begin
                issueD = 1'b1; hiloreadD = 1'b1;
            end
            #1;
            chk1($sformatf("div_t%0d_busy", k), div_busy, 1'b1);
            chk1($sformatf("div_t%0d_hilo", k), hilo_valid, 1'b0);
            chk_stall($sformatf("div_t%0d", k), k >= 2);
            @(negedge clk);
        end
        idle();
        issueD = 1'b1; divD = 1'b1;
        #1;
        chk1("div_t35_hilo", hilo_valid, 1'b1);
        chk1("div_t35_busy", div_busy, 1'b0);
        chk_stall("div_t35", 1'b0);
        @(negedge clk);

        // Back-to-back divide from DONE, then flushed mid-flight.
        for (int k = 1; k <= 9; k++) begin
            idle();
            if (k == 8) begin
                issueD = 1'b1; regwriteD = 1'b1; dstD = 5'd4; latD = 3'd7;
            end
            #1;
            chk1($sformatf("div2_t%0d_busy", k), div_busy, 1'b1);
            chk1($sformatf("div2_t%0d_hilo", k), hilo_valid, 1'b0);
            @(negedge clk);
        end
        idle();
        flush_all = 1'b1; issueD = 1'b1; hiloreadD = 1'b1; use_rsD = 1'b1; rsD = 5'd4;
        #1;
        chk_stall("flush_cycle", 1'b0);
        chk1("flush_cycle_hilo", hilo_valid, 1'b0);
        @(negedge clk);
        idle();
        issueD = 1'b1; use_rsD = 1'b1; rsD = 5'd4;
        #1;
        chk1("after_flush_busy", div_busy, 1'b0);
        chk_stall("after_flush_r4", 1'b0);
        @(negedge clk);
        pulses = 0;
        busy_seen = 0;
        for (int k = 0; k < 30; k++) begin
            idle();
            #1;
            if (hilo_valid) pulses++;
            if (div_busy) busy_seen++;
            @(negedge clk);
        end
        chk32("no_hilo_after_flush", 32'(pulses), 32'd0);
        chk32("no_busy_after_flush", 32'(busy_seen), 32'd0);
        chk32("div_stall_count", stall_count, 32'd34);

        // Load into r3 in the same cycle its previous pending count reaches 1.
        idle();
        issueD = 1'b1; regwriteD = 1'b1; dstD = 5'd3; latD = 3'd2;
        #1;
        @(negedge clk);
        idle();
        @(negedge clk);
        idle();
        issueD = 1'b1; regwriteD = 1'b1; dstD = 5'd3; latD = 3'd6;
        #1;
        chk_stall("ovw_issue", 1'b0);
        @(negedge clk);
        for (int k = 0; k <= 5; k++) begin
            idle();
            issueD = 1'b1; use_rsD = 1'b1; rsD = 5'd3;
            #1;
            chk_stall($sformatf("ovw_read%0d", k), k < 5);
            @(negedge clk);
        end
        idle();
        #1;
        chk32("ovw_stall_count", stall_count, 32'd39);
        @(negedge clk);

        // Stall counter saturation.
        idle();
        issueD = 1'b1; regwriteD = 1'b1; dstD = 5'd3; latD = 3'd6;
        #1;
        @(negedge clk);
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            idle();
            issueD = 1'b1; use_rsD = 1'b1; rsD = 5'd3;
            #1;
            chk_stall($sformatf("sat_stall%0d", k), 1'b1);
            if (k == 0) chk32("sat_start", stall_count, 32'hFFFF_FFFE);
            else chk32($sformatf("sat_cnt%0d", k), stall_count, 32'hFFFF_FFFF);
            @(negedge clk);
        end
        idle();
        #1;
        chk32("sat_hold", stall_count, 32'hFFFF_FFFF);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
